// File: rtl/program_loader.sv
// Byte-stream loader for the instruction memory.
// Packs 4 bytes big-endian into one instruction and writes it to word
// addresses 0..num_words-1, holding the CPU in reset while loading.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; last load failed validation or none yet
// S_RECV  | accepting bytes of the current word (byte_ready high)
// S_WRITE | single-cycle write strobe of the assembled word
// S_DONE  | load complete; CPU released; last address/data held
module program_loader #(
    parameter int DEPTH       = 32,
    parameter int COUNT_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_words,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic                   mem_write_enable,
    output logic [31:0]            mem_write_address,
    output logic [31:0]            mem_write_data,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] DEPTH_W  = COUNT_WIDTH'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] WORD_ONE = COUNT_WIDTH'(1);

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [COUNT_WIDTH-1:0]   r_num_words;
    logic [COUNT_WIDTH-1:0]   r_word_cnt;
    logic [1:0]               r_byte_cnt;
    logic [23:0]              r_shift;
    logic [31:0]              r_data;
    logic [COUNT_WIDTH-1:0]   r_addr;
    logic                     r_error;

    logic                     w_byte_ready;
    logic                     w_write_en;
    logic                     w_busy;
    logic                     w_done;
    logic                     w_start_window;
    logic                     w_start_accept;
    logic                     w_start_legal;
    logic                     w_byte_fire;
    logic                     w_last_byte;
    logic [COUNT_WIDTH-1:0]   w_word_cnt_inc;

    // A start is only honoured between loads; a zero or oversized count
    // would either do nothing or run past the end of the memory.
    assign w_start_window = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_start_accept = start && w_start_window;
    assign w_start_legal  = (num_words != '0) && (num_words <= DEPTH_W);
    assign w_byte_fire    = w_byte_ready && byte_valid;
    assign w_last_byte    = w_byte_fire && (r_byte_cnt == 2'd3);
    assign w_word_cnt_inc = r_word_cnt + WORD_ONE;

    // State register; reset drops straight back to IDLE, releasing the CPU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_byte_ready = 1'b0;
        w_write_en   = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_start_legal ? S_RECV : S_IDLE;
                end
            end
            S_RECV: begin
                w_byte_ready = 1'b1;
                w_busy       = 1'b1;
                if (byte_valid && (r_byte_cnt == 2'd3)) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_write_en  = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = (w_word_cnt_inc == r_num_words) ? S_DONE : S_RECV;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_state_nxt = w_start_legal ? S_RECV : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Load length and sticky error flag, both decided at start time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_num_words <= '0;
            r_error     <= 1'b0;
        end else if (w_start_accept) begin
            if (w_start_legal) begin
                r_num_words <= num_words;
                r_error     <= 1'b0;
            end else begin
                r_error <= 1'b1;
            end
        end
    end

    // Byte and word counters; a legal start rewinds both to the beginning.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_cnt <= 2'd0;
            r_word_cnt <= '0;
        end else if (w_start_accept && w_start_legal) begin
            r_byte_cnt <= 2'd0;
            r_word_cnt <= '0;
        end else begin
            if (w_byte_fire) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (r_state == S_WRITE) begin
                r_word_cnt <= w_word_cnt_inc;
            end
        end
    end

    // Big-endian word assembly; the completed word and its address are
    // captured on the 4th byte so they are stable through WRITE and DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_data  <= '0;
            r_addr  <= '0;
        end else if (w_last_byte) begin
            r_data <= {r_shift, byte_in};
            r_addr <= r_word_cnt;
        end else if (w_byte_fire) begin
            r_shift <= {r_shift[15:0], byte_in};
        end
    end

    assign byte_ready        = w_byte_ready;
    assign mem_write_enable  = w_write_en;
    assign mem_write_address = {{(32 - COUNT_WIDTH){1'b0}}, r_addr};
    assign mem_write_data    = r_data;
    assign cpu_hold          = w_busy;
    assign busy              = w_busy;
    assign done              = w_done;
    assign error             = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed scenarios plus randomized loads,
// checked every cycle against a transaction-level model of the loader.
module tb_program_loader;
    localparam int DEPTH = 32;
    localparam int CW    = 6;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          start      = 1'b0;
    logic [CW-1:0] num_words  = '0;
    logic [7:0]    byte_in    = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          mem_write_enable;
    logic [31:0]   mem_write_address;
    logic [31:0]   mem_write_data;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;

    program_loader #(.DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .num_words         (num_words),
        .byte_in           (byte_in),
        .byte_valid        (byte_valid),
        .byte_ready        (byte_ready),
        .mem_write_enable  (mem_write_enable),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .cpu_hold          (cpu_hold),
        .busy              (busy),
        .done              (done),
        .error             (error)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    // Transaction-level model: a load is active from a legal start until
    // num_words words have been written; each 4 accepted bytes yield one
    // write cycle during which no byte is taken.
    bit          m_active = 0;
    bit          m_wpend  = 0;
    bit          m_done   = 0;
    bit          m_err    = 0;
    int          m_target = 0;
    int          m_nwr    = 0;
    int          m_nb     = 0;
    int unsigned m_buf [4];
    int unsigned m_wdata  = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 0; m_wpend = 0; m_done = 0; m_err = 0;
            m_nwr = 0; m_nb = 0; m_wdata = 0;
        end else if (m_wpend) begin
            m_wpend = 0;
            m_nwr++;
            if (m_nwr == m_target) begin
                m_active = 0;
                m_done   = 1;
            end
        end else if (m_active) begin
            if (byte_valid) begin
                m_buf[m_nb] = int'(byte_in);
                m_nb++;
                if (m_nb == 4) begin
                    m_wdata = m_buf[0] * 32'd16777216 + m_buf[1] * 32'd65536
                            + m_buf[2] * 32'd256 + m_buf[3];
                    m_nb    = 0;
                    m_wpend = 1;
                end
            end
        end else if (start) begin
            m_done = 0;
            if (num_words == 0 || int'(num_words) > DEPTH) begin
                m_err = 1;
            end else begin
                m_err    = 0;
                m_active = 1;
                m_target = int'(num_words);
                m_nwr    = 0;
                m_nb     = 0;
            end
        end
    end

    bit          chk_en = 0;
    logic [63:0] wq [$];

    // Per-cycle comparison against the model, plus write capture.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("byte_ready", 64'(byte_ready), 64'(m_active && !m_wpend));
            chk("write_en",   64'(mem_write_enable), 64'(m_wpend));
            chk("busy",       64'(busy), 64'(m_active));
            chk("cpu_hold",   64'(cpu_hold), 64'(m_active));
            chk("done",       64'(done), 64'(m_done));
            chk("error",      64'(error), 64'(m_err));
            if (m_wpend) begin
                chk("wr_addr", 64'(mem_write_address), 64'(m_nwr));
                chk("wr_data", 64'(mem_write_data), 64'(m_wdata));
            end else if (m_done) begin
                chk("done_addr", 64'(mem_write_address), 64'(m_nwr - 1));
                chk("done_data", 64'(mem_write_data), 64'(m_wdata));
            end
        end
        if (rst && mem_write_enable) wq.push_back({mem_write_address, mem_write_data});
    end

    logic [7:0] stim [$];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input int n);
        start     = 1'b1;
        num_words = CW'(n);
        tick();
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard = 0;
        repeat (gap) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            tick();
        end
        byte_valid = 1'b1;
        byte_in    = b;
        while (byte_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (byte_ready !== 1'b1) chk("ready_timeout", 64'(byte_ready), 64'd1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_stream(input int first, input int last, input int maxgap);
        for (int i = first; i <= last; i++) send_byte(stim[i], $urandom_range(maxgap, 0));
    endtask

    task automatic wait_done();
        int g = 0;
        while (done !== 1'b1 && g < 40) begin
            tick();
            g++;
        end
        chk("done_reached", 64'(done), 64'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ready"}, 64'(byte_ready), 64'd0);
        chk({tag, "_we"},    64'(mem_write_enable), 64'd0);
        chk({tag, "_addr"},  64'(mem_write_address), 64'd0);
        chk({tag, "_data"},  64'(mem_write_data), 64'd0);
        chk({tag, "_hold"},  64'(cpu_hold), 64'd0);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_done"},  64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
    endtask

    task automatic check_writes(input string tag, input int n);
        logic [31:0] w;
        chk({tag, "_count"}, 64'(wq.size()), 64'(n));
        for (int k = 0; k < n && k < wq.size(); k++) begin
            w = {stim[4*k], stim[4*k+1], stim[4*k+2], stim[4*k+3]};
            chk({tag, "_word"}, wq[k], {32'(k), w});
        end
    endtask

    logic [7:0] basic_b [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};

    initial begin
        #1 rst = 1'b0;
        #1 check_zero_outputs("reset");
        chk_en = 1;
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Basic load, valid held high.
        stim.delete();
        foreach (basic_b[i]) stim.push_back(basic_b[i]);
        wq.delete();
        pulse_start(2);
        send_stream(0, 7, 0);
        wait_done();
        chk("basic_count", 64'(wq.size()), 64'd2);
        chk("basic_w0", wq[0], {32'd0, 32'h20080005});
        chk("basic_w1", wq[1], {32'd1, 32'h8C090004});
        chk("basic_hold", 64'(cpu_hold), 64'd0);
        tick();

        // Same stream with gaps between bytes.
        wq.delete();
        pulse_start(2);
        send_stream(0, 7, 2);
        wait_done();
        chk("gap_w0", wq[0], {32'd0, 32'h20080005});
        chk("gap_w1", wq[1], {32'd1, 32'h8C090004});
        check_writes("gap", 2);

        // Illegal lengths, then a legal start clears the error.
        wq.delete();
        pulse_start(0);
        chk("ill0_error", 64'(error), 64'd1);
        chk("ill0_done", 64'(done), 64'd0);
        tick();
        pulse_start(33);
        chk("ill33_error", 64'(error), 64'd1);
        chk("ill33_busy", 64'(busy), 64'd0);
        chk("ill_nowrite", 64'(wq.size()), 64'd0);
        pulse_start(1);
        chk("legal_error", 64'(error), 64'd0);
        chk("legal_busy", 64'(busy), 64'd1);
        send_stream(0, 3, 1);
        wait_done();
        check_writes("legal", 1);

        // Full memory: word k holds value k.
        stim.delete();
        for (int k = 0; k < DEPTH; k++) begin
            stim.push_back(8'h00); stim.push_back(8'h00);
            stim.push_back(8'h00); stim.push_back(8'(k));
        end
        wq.delete();
        pulse_start(DEPTH);
        send_stream(0, 4 * DEPTH - 1, 0);
        wait_done();
        chk("full_count", 64'(wq.size()), 64'd32);
        chk("full_last", wq[31], {32'd31, 32'd31});
        check_writes("full", DEPTH);

        // Reset in the middle of the second word.
        stim.delete();
        foreach (basic_b[i]) stim.push_back(basic_b[i]);
        wq.delete();
        pulse_start(2);
        send_stream(0, 5, 0);
        chk("mid_one_write", 64'(wq.size()), 64'd1);
        rst = 1'b0;
        #1 check_zero_outputs("midrst");
        tick();
        tick();
        rst = 1'b1;
        tick();
        wq.delete();
        pulse_start(1);
        send_stream(0, 3, 0);
        wait_done();
        chk("restart_w0", wq[0], {32'd0, 32'h20080005});

        // Start during RECV is ignored.
        wq.delete();
        pulse_start(2);
        send_stream(0, 1, 0);
        start     = 1'b1;
        num_words = CW'(5);
        send_byte(stim[2], 0);
        start     = 1'b0;
        send_stream(3, 7, 1);
        wait_done();
        repeat (3) tick();
        check_writes("busy_start", 2);

        // Randomized loads, sometimes preceded by an illegal start.
        for (int it = 0; it < 12; it++) begin
            int n;
            if ($urandom_range(3, 0) == 0) begin
                pulse_start(($urandom_range(1, 0) == 0) ? 0 : $urandom_range(63, 33));
                chk("rnd_ill_error", 64'(error), 64'd1);
            end
            n = $urandom_range(8, 1);
            stim.delete();
            for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
            wq.delete();
            pulse_start(n);
            send_stream(0, 4 * n - 1, 3);
            wait_done();
            check_writes("rnd", n);
            repeat ($urandom_range(2, 0)) tick();
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
